// File: rtl/ltc2387_pkg.sv
// ============================================================================
//  Module      : ltc2387_pkg
//  Description : Shared types, lane constants and bit-selection helper for the
//                LTC2387-18 serial output emulator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ltc2387_pkg;

   localparam int ADC_WIDTH_18   = 18;
   localparam int NEDGE_TWO_LANE = 10;
   localparam int NEDGE_ONE_LANE = 18;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   typedef enum logic {
      MODE_ONE_LANE = 1'b0,
      MODE_TWO_LANE = 1'b1
   } mode_e;

   // Returns {da, db} for DCO edge k; edges past the data (two-lane pad) are 0.
   function automatic logic [1:0] lane_bits(input logic [ADC_WIDTH_18-1:0] word,
                                            input mode_e mode,
                                            input logic [4:0] k);
      logic [1:0] bits;
      logic [4:0] idx;
      bits = 2'b00;
      idx  = 5'd0;
      if (mode == MODE_TWO_LANE) begin
         if (k < 5'd9) begin
            idx  = 5'd17 - {k[3:0], 1'b0};
            bits = {word[idx], word[idx - 5'd1]};
         end
      end else begin
         if (k < 5'd18) begin
            idx  = 5'd17 - k;
            bits = {word[idx], 1'b0};
         end
      end
      return bits;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ltc2387_lane_serializer.sv
// ============================================================================
//  Module      : ltc2387_lane_serializer
//  Description : Shifts one word out on da/db with a DCO edge centred on each
//                lane bit; two sys clocks per DCO edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ltc2387_lane_serializer
   import ltc2387_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [ADC_WIDTH_18-1:0] word_i,
   input  mode_e                   mode_i,
   output logic                    dco_o,
   output logic                    da_o,
   output logic                    db_o,
   output logic                    done_o
);

   logic       active_q, active_d;
   logic       phase_q,  phase_d;
   logic [4:0] k_q,      k_d;
   logic       dco_q,    dco_d;
   logic       da_q,     da_d;
   logic       db_q,     db_d;
   logic [4:0] last_k;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_q <= 1'b0;
         phase_q  <= 1'b0;
         k_q      <= 5'd0;
         dco_q    <= 1'b0;
         da_q     <= 1'b0;
         db_q     <= 1'b0;
      end else begin
         active_q <= active_d;
         phase_q  <= phase_d;
         k_q      <= k_d;
         dco_q    <= dco_d;
         da_q     <= da_d;
         db_q     <= db_d;
      end
   end

   // Phase 0 shows the bit for edge k, phase 1 toggles DCO; the next bit is
   // loaded on the same clock that ends phase 1.
   always_comb begin
      active_d = active_q;
      phase_d  = phase_q;
      k_d      = k_q;
      dco_d    = dco_q;
      da_d     = da_q;
      db_d     = db_q;
      done_o   = 1'b0;
      last_k   = (mode_i == MODE_TWO_LANE) ? 5'(NEDGE_TWO_LANE - 1)
                                           : 5'(NEDGE_ONE_LANE - 1);
      if (start_i) begin
         active_d     = 1'b1;
         phase_d      = 1'b0;
         k_d          = 5'd0;
         dco_d        = 1'b0;
         {da_d, db_d} = lane_bits(word_i, mode_i, 5'd0);
      end else if (active_q) begin
         if (!phase_q) begin
            dco_d   = ~dco_q;
            phase_d = 1'b1;
         end else if (k_q == last_k) begin
            da_d     = 1'b0;
            db_d     = 1'b0;
            active_d = 1'b0;
            phase_d  = 1'b0;
            done_o   = 1'b1;
         end else begin
            k_d          = k_q + 5'd1;
            phase_d      = 1'b0;
            {da_d, db_d} = lane_bits(word_i, mode_i, k_q + 5'd1);
         end
      end
   end

   assign dco_o = dco_q;
   assign da_o  = da_q;
   assign db_o  = db_q;

endmodule

`default_nettype wire

// File: rtl/ltc2387_18_adc_emulator.sv
// ============================================================================
//  Module      : ltc2387_18_adc_emulator
//  Description : Device-side LTC2387-18 model: cnv/tl in, DCO-framed da/db
//                burst out, samples fed through a one-deep valid/ready buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ltc2387_18_adc_emulator
   import ltc2387_pkg::*;
#(
   parameter int ADC_WIDTH   = 18,
   parameter int CONV_CYCLES = 4
) (
   input  logic                 sys_clk_int,
   input  logic                 reset_n_int,
   input  logic                 cnv,
   input  logic                 tl,
   input  logic [ADC_WIDTH-1:0] sample_data,
   input  logic                 sample_valid,
   output logic                 sample_ready,
   output logic                 dco,
   output logic                 da,
   output logic                 db,
   output logic                 busy,
   output logic                 cnv_overrun,
   output logic                 sample_underrun
);

   localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q,   cnt_d;
   mode_e                mode_q,  mode_d;
   logic [ADC_WIDTH-1:0] last_q,  last_d;
   logic [ADC_WIDTH-1:0] hold_q,  hold_d;
   logic                 full_q,  full_d;
   logic                 cnv_q;
   logic                 busy_q,  busy_d;
   logic                 ovr_q,   ovr_d;
   logic                 und_q,   und_d;
   logic                 cnv_edge;
   logic                 load_hold;
   logic                 ser_start;
   logic                 ser_done;

   assign cnv_edge = cnv & ~cnv_q;

   always_ff @(posedge sys_clk_int or negedge reset_n_int) begin
      if (!reset_n_int) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mode_q  <= MODE_ONE_LANE;
         last_q  <= '0;
         hold_q  <= '0;
         full_q  <= 1'b0;
         cnv_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         full_q  <= full_d;
         cnv_q   <= cnv;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
         und_q   <= und_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      last_d    = last_q;
      hold_d    = hold_q;
      full_d    = full_q;
      busy_d    = busy_q;
      ovr_d     = 1'b0;
      und_d     = 1'b0;
      ser_start = 1'b0;
      load_hold = sample_valid & ~full_q;

      case (state_q)
         ST_IDLE: begin
            if (cnv_edge) begin
               mode_d = tl ? MODE_TWO_LANE : MODE_ONE_LANE;
               // Buffered sample first, then a bypass of the live input,
               // otherwise repeat the previous word and flag it.
               if (full_q) begin
                  last_d = hold_q;
                  full_d = 1'b0;
               end else if (sample_valid) begin
                  last_d    = sample_data;
                  load_hold = 1'b0;
               end else begin
                  und_d = 1'b1;
               end
               state_d = ST_CONV;
               cnt_d   = CW'(CONV_CYCLES - 1);
               busy_d  = 1'b1;
            end
         end
         ST_CONV: begin
            if (cnt_q == '0) begin
               state_d   = ST_SHIFT;
               ser_start = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_SHIFT: begin
            if (ser_done) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (cnv_edge && (state_q != ST_IDLE)) begin
         ovr_d = 1'b1;
      end

      if (load_hold) begin
         hold_d = sample_data;
         full_d = 1'b1;
      end
   end

   ltc2387_lane_serializer u_serializer (
      .clk_i   (sys_clk_int),
      .rst_ni  (reset_n_int),
      .start_i (ser_start),
      .word_i  (last_q),
      .mode_i  (mode_q),
      .dco_o   (dco),
      .da_o    (da),
      .db_o    (db),
      .done_o  (ser_done)
   );

   assign sample_ready    = ~full_q;
   assign busy            = busy_q;
   assign cnv_overrun     = ovr_q;
   assign sample_underrun = und_q;

endmodule

`default_nettype wire
